// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write bus of the program loader.
// A byte moves on every rising clk edge where rx_valid && rx_ready; rx_data must be stable while rx_valid is high, and rx_ready never depends on rx_valid.
interface imem_loader_if #(
  parameter int ADDR_W = 8
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              we;
  logic [ADDR_W-1:0] w_addr;
  logic [31:0]       w_ins;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, we, w_addr, w_ins
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, we, w_addr, w_ins
  );
endinterface

// File: rtl/imem_loader.sv
// Program loader: takes [LEN_LO][LEN_HI][4*LEN data bytes][CSUM] and writes
// little-endian words into instruction memory while holding the CPU.
module imem_loader #(
  parameter int ADDR_W      = 8,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  imem_loader_if.slave    bus,
  output logic            cpu_hold,
  output logic            loaded,
  output logic            err,
  output logic [1:0]      err_code,
  output logic [ADDR_W:0] word_cnt,
  output logic [2:0]      state_dbg
);
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [TW-1:0] IDLE_LIMIT = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] IDLE_ONE = {{(TW-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] WC_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [16:0] MAX_LEN = 17'(1) << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       len_q;
  logic [31:0]       word_q;
  logic [1:0]        byte_idx;
  logic [7:0]        sum_q;
  logic [TW-1:0]     idle_cnt;
  logic [ADDR_W-1:0] w_addr_q;
  logic [31:0]       w_ins_q;
  logic [1:0]        err_code_q;
  logic [ADDR_W:0]   word_cnt_q;

  logic        active, accept, timed_out, start_load, len_bad, last_word, csum_ok;
  logic [15:0] hdr_len;

  assign active     = state_q inside {S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM};
  assign accept     = active && bus.rx_valid;
  // An accept in the limit cycle wins over the timeout.
  assign timed_out  = active && !accept && (idle_cnt == IDLE_LIMIT);
  assign start_load = start && (state_q inside {S_IDLE, S_DONE, S_ERR});
  assign hdr_len    = {bus.rx_data, len_q[7:0]};
  assign len_bad    = (hdr_len == 16'd0) || ({1'b0, hdr_len} > MAX_LEN);
  assign last_word  = (17'(word_cnt_q) + 17'd1) == {1'b0, len_q};
  assign csum_ok    = (bus.rx_data == sum_q);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start_load) begin
      state_d = S_LEN_LO;
    end else if (timed_out) begin
      state_d = S_ERR;
    end else begin
      case (state_q)
        S_LEN_LO: if (accept) state_d = S_LEN_HI;
        S_LEN_HI: if (accept) state_d = len_bad ? S_ERR : S_DATA;
        S_DATA:   if (accept && byte_idx == 2'd3) state_d = S_WRITE;
        S_WRITE:  state_d = last_word ? S_CSUM : S_DATA;
        S_CSUM:   if (accept) state_d = csum_ok ? S_DONE : S_ERR;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q      <= '0;
      word_q     <= '0;
      byte_idx   <= '0;
      sum_q      <= '0;
      idle_cnt   <= '0;
      w_addr_q   <= '0;
      w_ins_q    <= '0;
      err_code_q <= '0;
      word_cnt_q <= '0;
    end else if (start_load) begin
      len_q      <= '0;
      word_q     <= '0;
      byte_idx   <= '0;
      sum_q      <= '0;
      idle_cnt   <= '0;
      err_code_q <= '0;
      word_cnt_q <= '0;
    end else begin
      // Idle counter is frozen in WRITE since no byte can be taken there.
      if (active) idle_cnt <= accept ? '0 : idle_cnt + IDLE_ONE;
      if (timed_out) err_code_q <= 2'd3;
      if (accept) begin
        case (state_q)
          S_LEN_LO: len_q[7:0] <= bus.rx_data;
          S_LEN_HI: begin
            len_q[15:8] <= bus.rx_data;
            if (len_bad) err_code_q <= 2'd1;
          end
          S_DATA: begin
            word_q[{byte_idx, 3'b000} +: 8] <= bus.rx_data;
            sum_q    <= sum_q + bus.rx_data;
            byte_idx <= byte_idx + 2'd1;
            // Write bus is loaded here so it is valid for the whole WRITE cycle.
            if (byte_idx == 2'd3) begin
              w_ins_q  <= {bus.rx_data, word_q[23:0]};
              w_addr_q <= word_cnt_q[ADDR_W-1:0];
            end
          end
          S_CSUM: if (!csum_ok) err_code_q <= 2'd2;
          default: ;
        endcase
      end
      if (state_q == S_WRITE) word_cnt_q <= word_cnt_q + WC_ONE;
    end
  end

  assign bus.rx_ready = active;
  assign bus.we       = (state_q == S_WRITE);
  assign bus.w_addr   = w_addr_q;
  assign bus.w_ins    = w_ins_q;
  assign cpu_hold     = !(state_q inside {S_IDLE, S_DONE});
  assign loaded       = (state_q == S_DONE);
  assign err          = (state_q == S_ERR);
  assign err_code     = err_code_q;
  assign word_cnt     = word_cnt_q;
  assign state_dbg    = state_q;
endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: random frames driven over the byte stream, checked
// against a frame-level model of expected writes and final status.
module tb_imem_loader;
  localparam int ADDR_W      = 8;
  localparam int TIMEOUT_CYC = 16;
  localparam int MAX_LEN     = 2 ** ADDR_W;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            cpu_hold, loaded, err;
  logic [1:0]      err_code;
  logic [ADDR_W:0] word_cnt;
  logic [2:0]      state_dbg;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus),
    .cpu_hold(cpu_hold), .loaded(loaded), .err(err), .err_code(err_code),
    .word_cnt(word_cnt), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int we_cnt = 0;
  logic [ADDR_W+31:0] exp_q[$];
  logic [7:0] frame[$];
  logic [7:0] t1_bytes [0:10];
  logic exp_loaded, exp_err;
  logic [1:0] exp_code;
  int exp_wc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (bus.we === 1'b1) begin
      we_cnt++;
      if (exp_q.size() == 0) check("we_unexpected", 1, 0);
      else check("we_addr_word", {bus.w_addr, bus.w_ins}, exp_q.pop_front());
    end
  end

  // ---------------- reference model ----------------
  // Works on the whole frame: header -> length rule, words -> expected writes,
  // checksum -> final status. Returns how many bytes the loader will consume.
  task automatic model_frame(output int n_used);
    int len;
    logic [7:0] s;
    logic [31:0] w;
    len = int'(frame[0]) + 256 * int'(frame[1]);
    if (len == 0 || len > MAX_LEN) begin
      exp_loaded = 0; exp_err = 1; exp_code = 2'd1; exp_wc = 0; n_used = 2;
      return;
    end
    s = 0;
    for (int i = 0; i < len; i++) begin
      w = 0;
      for (int j = 0; j < 4; j++) begin
        w = w | (32'(frame[2 + 4*i + j]) << (8*j));
        s = s + frame[2 + 4*i + j];
      end
      exp_q.push_back({ADDR_W'(i), w});
    end
    n_used = 3 + 4*len;
    exp_wc = len;
    if (frame[n_used-1] == s) begin
      exp_loaded = 1; exp_err = 0; exp_code = 2'd0;
    end else begin
      exp_loaded = 0; exp_err = 1; exp_code = 2'd2;
    end
  endtask

  task automatic build_frame(input int len, input bit bad_csum);
    logic [7:0] s, b;
    frame.delete();
    frame.push_back(8'(len));
    frame.push_back(8'(len >> 8));
    s = 0;
    for (int i = 0; i < 4*len; i++) begin
      b = 8'($urandom);
      frame.push_back(b);
      s = s + b;
    end
    frame.push_back(bad_csum ? (s ^ 8'($urandom_range(255, 1))) : s);
  endtask

  task automatic load_t1(input logic [7:0] csum);
    frame.delete();
    for (int i = 0; i < 10; i++) frame.push_back(t1_bytes[i]);
    frame.push_back(csum);
  endtask

  // ---------------- drivers ----------------
  task automatic pulse_start();
    @(negedge clk); start = 1'b1; bus.rx_valid = 1'b0;
    @(negedge clk); start = 1'b0;
  endtask

  // Optional random gaps (rx_valid low, junk data, stray START pulses), then
  // hold the byte until it is accepted. Returns 1 time unit after the accept edge.
  task automatic send_byte(input logic [7:0] b, input int max_gap, input bit noise);
    int guard;
    bit rdy;
    repeat ($urandom_range(max_gap, 0)) begin
      @(negedge clk);
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'($urandom);
      start = noise && ($urandom_range(2, 0) == 0);
    end
    guard = 0;
    forever begin
      @(negedge clk);
      start = 1'b0;
      bus.rx_valid = 1'b1;
      bus.rx_data  = b;
      rdy = bus.rx_ready;
      @(posedge clk);
      if (rdy) break;
      guard++;
      if (guard > 50) begin
        check("accept_wait_expired", 0, 1);
        break;
      end
    end
    #1 bus.rx_valid = 1'b0;
  endtask

  task automatic run_frame(input int max_gap, input bit noise);
    int n, we0;
    model_frame(n);
    we0 = we_cnt;
    pulse_start();
    for (int i = 0; i < n; i++) send_byte(frame[i], max_gap, noise && i > 0);
    @(negedge clk);
    check("loaded", loaded, exp_loaded);
    check("err", err, exp_err);
    check("err_code", err_code, exp_code);
    check("word_cnt", word_cnt, exp_wc);
    check("cpu_hold", cpu_hold, exp_err);
    check("rx_ready_after", bus.rx_ready, 0);
    check("we_pulses", we_cnt - we0, exp_wc);
    check("writes_left", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic check_reset_vals();
    check("rst_rx_ready", bus.rx_ready, 0);
    check("rst_we", bus.we, 0);
    check("rst_w_addr", bus.w_addr, 0);
    check("rst_w_ins", bus.w_ins, 0);
    check("rst_cpu_hold", cpu_hold, 0);
    check("rst_loaded", loaded, 0);
    check("rst_err", err, 0);
    check("rst_err_code", err_code, 0);
    check("rst_word_cnt", word_cnt, 0);
  endtask

  task automatic timeout_latency(input string tag);
    int lat;
    lat = 0;
    for (int c = 1; c <= 3*TIMEOUT_CYC && lat == 0; c++) begin
      @(posedge clk); #1;
      if (err_code == 2'd3) lat = c;
    end
    check(tag, lat, TIMEOUT_CYC);
    check({tag, "_err"}, err, 1);
    check({tag, "_hold"}, cpu_hold, 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int we0, len;
    t1_bytes = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h4C};
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_vals();

    // Known frame: writes (0,12345678), (1,DEADBEEF), good checksum.
    load_t1(8'h4C);
    run_frame(0, 0);

    // Bytes offered while not loading are ignored.
    we0 = we_cnt;
    repeat (4) begin
      @(negedge clk);
      bus.rx_valid = 1'b1;
      bus.rx_data  = 8'($urandom);
      check("ready_when_done", bus.rx_ready, 0);
    end
    @(negedge clk); bus.rx_valid = 1'b0;
    check("still_loaded", loaded, 1);
    check("no_we_when_done", we_cnt - we0, 0);

    // Same frame, wrong checksum.
    load_t1(8'h4D);
    run_frame(0, 0);

    // Bad lengths: 0 and 257.
    frame.delete(); frame.push_back(8'h00); frame.push_back(8'h00);
    run_frame(0, 0);
    frame.delete(); frame.push_back(8'h01); frame.push_back(8'h01);
    run_frame(0, 0);

    // Timeout mid-data: 16 cycles after the last accept, no writes.
    we0 = we_cnt;
    pulse_start();
    send_byte(8'h02, 0, 0);
    send_byte(8'h00, 0, 0);
    send_byte(8'h78, 0, 0);
    timeout_latency("timeout_data");
    check("timeout_no_we", we_cnt - we0, 0);

    // Timeout with no bytes at all, counted from entering LEN_LO.
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    timeout_latency("timeout_len_lo");

    // Known frame with random valid gaps and stray START pulses.
    load_t1(8'h4C);
    run_frame(3, 1);

    // Random frames, some with corrupted checksum.
    for (int t = 0; t < 8; t++) begin
      build_frame($urandom_range(8, 1), $urandom_range(1, 0) == 1);
      run_frame($urandom_range(3, 0), 1);
    end

    // Largest image.
    build_frame(MAX_LEN, 0);
    run_frame(1, 0);

    // Random out-of-range lengths.
    for (int t = 0; t < 3; t++) begin
      len = $urandom_range(65535, MAX_LEN + 1);
      frame.delete(); frame.push_back(8'(len)); frame.push_back(8'(len >> 8));
      run_frame(2, 0);
    end

    // Reset lands on the edge that would take the last byte of word 0.
    we0 = we_cnt;
    pulse_start();
    send_byte(8'h02, 0, 0);
    send_byte(8'h00, 0, 0);
    send_byte(8'h78, 0, 0);
    send_byte(8'h56, 0, 0);
    send_byte(8'h34, 0, 0);
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h12;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.rx_valid = 1'b0;
    check_reset_vals();
    repeat (4) @(negedge clk);
    check("no_we_after_rst", we_cnt - we0, 0);
    load_t1(8'h4C);
    run_frame(1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    n_bad++;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1);
  end
endmodule
